axi_memory_writer_burst: RTL

- AXI4 write-burst master; the write-side counterpart of the frame read path.
- Accepts a write command (address, beat count) plus a valid/ready pixel-word stream, e.g. Wiener-filtered blocks.
- Issues one INCR burst on AW/W/B to AXI memory and reports completion and response status.
- Holds a small prefetch FIFO so upstream data can be absorbed while the address phase is pending.

---
 rtl/axi_memory_writer_burst.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/axi_memory_writer_burst.sv
// AXI4 single-burst write master with a small prefetch FIFO.
// One command produces exactly one AW, len W beats and one B handshake.
module axi_memory_writer_burst #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_write,
   input  logic [ADDR_WIDTH-1:0]     write_addr,
   input  logic [31:0]               write_len,
   input  logic [2:0]                write_size,
   input  logic [1:0]                write_burst,
   input  logic [DATA_WIDTH-1:0]     data_in,
   input  logic                      data_valid,
   output logic                      data_ready,
   output logic [ADDR_WIDTH-1:0]     awaddr,
   output logic [7:0]                awlen,
   output logic [2:0]                awsize,
   output logic [1:0]                awburst,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [DATA_WIDTH-1:0]     wdata,
   output logic [DATA_WIDTH/8-1:0]   wstrb,
   output logic                      wlast,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready,
   output logic                      busy,
   output logic                      write_done,
   output logic                      write_error
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned PTR_WIDTH  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_WIDTH  = PTR_WIDTH + 1;
   localparam int unsigned BEAT_WIDTH = 9;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q;
   logic [7:0]              awlen_q;
   logic [2:0]              awsize_q;
   logic [1:0]              awburst_q;
   logic                    awvalid_q;
   logic                    bready_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    error_q;
   logic [BEAT_WIDTH-1:0]   len_q;
   logic [BEAT_WIDTH-1:0]   beat_cnt_q;
   logic [BEAT_WIDTH-1:0]   acc_cnt_q;

   logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]    wr_ptr_q;
   logic [PTR_WIDTH-1:0]    rd_ptr_q;
   logic [CNT_WIDTH-1:0]    fifo_cnt_q;

   logic fifo_empty_c;
   logic fifo_full_c;
   logic last_beat_c;
   logic pop_c;
   logic push_c;
   logic len_ok_c;
   logic resp_err_c;

   // FIFO status, beat handshakes and command legality
   always_comb begin
      fifo_empty_c = (fifo_cnt_q == '0);
      fifo_full_c  = (fifo_cnt_q == CNT_WIDTH'(FIFO_DEPTH));
      last_beat_c  = (beat_cnt_q == BEAT_WIDTH'(len_q - BEAT_WIDTH'(1)));
      pop_c        = (state_q == S_DATA) && !fifo_empty_c && wready;
      push_c       = data_valid && data_ready;
      len_ok_c     = (write_len != 32'd0) && (write_len <= 32'd256);
      resp_err_c   = (bresp == 2'b10) || (bresp == 2'b11);
   end

   // A full FIFO still accepts a word in the cycle its head is popped
   assign data_ready  = busy_q && (!fifo_full_c || pop_c) && (acc_cnt_q < len_q);

   assign awaddr      = awaddr_q;
   assign awlen       = awlen_q;
   assign awsize      = awsize_q;
   assign awburst     = awburst_q;
   assign awvalid     = awvalid_q;
   assign wvalid      = (state_q == S_DATA) && !fifo_empty_c;
   assign wlast       = wvalid && last_beat_c;
   assign wdata       = fifo_mem_q[rd_ptr_q];
   assign wstrb       = {STRB_WIDTH{wvalid}};
   assign bready      = bready_q;
   assign busy        = busy_q;
   assign write_done  = done_q;
   assign write_error = error_q;

   // Prefetch FIFO storage and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push_c) begin
            fifo_mem_q[wr_ptr_q] <= data_in;
            wr_ptr_q             <= wr_ptr_q + PTR_WIDTH'(1);
         end
         if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
         case ({push_c, pop_c})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_WIDTH'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_WIDTH'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   // Command FSM: address phase, data beats, response, completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         awaddr_q   <= '0;
         awlen_q    <= '0;
         awsize_q   <= '0;
         awburst_q  <= '0;
         awvalid_q  <= 1'b0;
         bready_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         acc_cnt_q  <= '0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         if (push_c) acc_cnt_q <= acc_cnt_q + BEAT_WIDTH'(1);
         case (state_q)
            S_IDLE: begin
               if (start_write) begin
                  if (len_ok_c) begin
                     state_q    <= S_ADDR;
                     awaddr_q   <= write_addr;
                     awlen_q    <= 8'(write_len - 32'd1);
                     awsize_q   <= write_size;
                     awburst_q  <= write_burst;
                     len_q      <= BEAT_WIDTH'(write_len);
                     beat_cnt_q <= '0;
                     acc_cnt_q  <= '0;
                     awvalid_q  <= 1'b1;
                     busy_q     <= 1'b1;
                  end else begin
                     done_q  <= 1'b1;
                     error_q <= 1'b1;
                  end
               end
            end
            S_ADDR: begin
               if (awready) begin
                  awvalid_q <= 1'b0;
                  state_q   <= S_DATA;
               end
            end
            S_DATA: begin
               if (pop_c) begin
                  beat_cnt_q <= beat_cnt_q + BEAT_WIDTH'(1);
                  if (last_beat_c) begin
                     state_q  <= S_RESP;
                     bready_q <= 1'b1;
                  end
               end
            end
            S_RESP: begin
               if (bvalid) begin
                  bready_q <= 1'b0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  error_q  <= resp_err_c;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
